// File: rtl/seven_seg_pkg.sv
// Shared seven-segment definitions: segment type, dash/blank codes and the
// 16-entry BCD decode table used by every seven-segment block.
package seven_seg_pkg;

    // Segment bus ordered {g,f,e,d,c,b,a}, active high.
    typedef logic [6:0] seg_t;

    localparam seg_t SEG_DASH  = 7'h40;
    localparam seg_t SEG_BLANK = 7'h00;

    // Codes 10..15 are not valid BCD and render as a dash.
    localparam seg_t SEG_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH,
        SEG_DASH, SEG_DASH
    };

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD to seven-segment decode, one digit.
module bcd_to_seg
    import seven_seg_pkg::*;
(
    input  logic [3:0] bcd,
    output seg_t       seg
);

    assign seg = SEG_TABLE[bcd];

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed seven-segment scan driver with frame-aligned double
// buffering. Optional feature macro: LEADING_ZERO_BLANK_EN blanks leading
// zero digits above digit 0.
module seven_seg_scan_driver
    import seven_seg_pkg::*;
#(
    parameter int DIGITS  = 4,
    parameter int CLK_DIV = 1000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   bcd_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  load,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_done
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);
    localparam logic [IW-1:0] IDX_MAX = IW'(DIGITS - 1);

    logic [CW-1:0]             cnt;
    logic [IW-1:0]             idx;
    logic                      tick;
    logic                      boundary;

    // Display buffer drives the scan; pending buffer holds the next frame.
    logic [DIGITS-1:0][3:0]    disp_bcd;
    logic [DIGITS-1:0][3:0]    pend_bcd;
    logic [DIGITS-1:0]         disp_dp;
    logic [DIGITS-1:0]         pend_dp;
    logic                      pend_vld;

    logic [DIGITS-1:0][6:0]    dig_seg;
    logic [DIGITS-1:0]         blank;
    logic [DIGITS-1:0]         an_nxt;

    assign tick     = (cnt == CNT_MAX);
    assign boundary = tick && (idx == IDX_MAX);
    assign an_nxt   = {{(DIGITS-1){1'b0}}, 1'b1} << idx;

    // Prescaler: one tick per digit slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     cnt <= '0;
        else if (tick)  cnt <= '0;
        else            cnt <= cnt + 1'b1;
    end

    // Digit index advances after each slot is loaded into the output regs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         idx <= '0;
        else if (tick) begin
            if (idx == IDX_MAX) idx <= '0;
            else                idx <= idx + 1'b1;
        end
    end

    // Double buffer: loads park in pending and swap in only at the frame
    // boundary, so the last digit of a frame still reads the old display
    // value (non-blocking update) and a frame never mixes old and new data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_bcd <= '0;
            disp_dp  <= '0;
            pend_bcd <= '0;
            pend_dp  <= '0;
            pend_vld <= 1'b0;
        end else if (load && boundary) begin
            disp_bcd <= bcd_in;
            disp_dp  <= dp_in;
            pend_vld <= 1'b0;
        end else begin
            if (boundary && pend_vld) begin
                disp_bcd <= pend_bcd;
                disp_dp  <= pend_dp;
                pend_vld <= 1'b0;
            end
            if (load) begin
                pend_bcd <= bcd_in;
                pend_dp  <= dp_in;
                pend_vld <= 1'b1;
            end
        end
    end

    // One decoder per digit; the scan mux picks the active one.
    for (genvar g = 0; g < DIGITS; g++) begin : g_dig
        bcd_to_seg u_dec (
            .bcd (disp_bcd[g]),
            .seg (dig_seg[g])
        );
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic zero_run;

    // A digit above 0 blanks when it and everything above it is zero.
    always_comb begin
        blank    = '0;
        zero_run = 1'b1;
        for (int i = DIGITS-1; i > 0; i--) begin
            zero_run = zero_run && (disp_bcd[i] == 4'd0);
            blank[i] = zero_run;
        end
    end
`else
    // Every digit decodes normally.
    always_comb begin
        blank = '0;
    end
`endif

    // Registered pin outputs, refreshed once per digit slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg <= '0;
            dp  <= 1'b0;
            an  <= '0;
        end else if (tick) begin
            seg <= blank[idx] ? SEG_BLANK : dig_seg[idx];
            dp  <= disp_dp[idx];
            an  <= an_nxt;
        end
    end

    // Frame-end pulse, one cycle after the boundary tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) frame_done <= 1'b0;
        else        frame_done <= boundary;
    end

endmodule
